// File: rtl/register_file_sb_pkg.sv
// Shared parameters and the pending-bit update rule for register_file_sb.
// Optional bypass feature is selected with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  localparam int ZERO_REG = 0;

  // Priority is flush, then set, then clear; set wins so the newer producer stays outstanding.
  function automatic logic next_pending(input logic cur,
                                        input logic set,
                                        input logic clr,
                                        input logic flush_all);
    if (flush_all) return 1'b0;
    if (set)       return 1'b1;
    if (clr)       return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/write-back bus of register_file_sb: read ports, write-back, issue marking, scoreboard.
// The master side drives addresses and strobes; the slave side is the register file.
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;

  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     flush;

  logic [(2**ADDR_W)-1:0]   pending;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data, rd_busy, pending
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data, rd_busy, pending
  );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// reg_scoreboard: one pending flop per register, set on issue, cleared on write-back,
// all cleared by flush. Register 0 never becomes pending.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   flush,
  output logic [(2**ADDR_W)-1:0] pending
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] pending_nxt;

  always_comb begin
    set_vec     = '0;
    clr_vec     = '0;
    pending_nxt = '0;
    if (issue_en && (issue_addr != ZERO_A)) set_vec[issue_addr] = 1'b1;
    if (wr_en) clr_vec[wr_addr] = 1'b1;
    for (int r = 1; r < DEPTH; r++) begin
      pending_nxt[r] = next_pending(pending[r], set_vec[r], clr_vec[r], flush);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: clocked-write register file with combinational read ports and a
// write-pending scoreboard. Define REGFILE_BYPASS_EN to forward write-back data to reads.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input logic              clk,
  input logic              rst_n,
  register_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending_vec;
  logic              wr_valid;

  assign wr_valid = bus.wr_en && (bus.wr_addr != ZERO_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_valid) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .flush      (bus.flush),
    .pending    (pending_vec)
  );

  assign bus.pending = pending_vec;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic              nonzero;

    assign addr    = bus.rd_addr[gi*ADDR_W +: ADDR_W];
    assign nonzero = (addr != ZERO_A);
    assign stored  = nonzero ? mem[addr] : '0;

`ifdef REGFILE_BYPASS_EN
    // Forwarding is held off during reset so outputs stay zero while rst_n is low.
    logic hit;
    assign hit = rst_n && wr_valid && (bus.wr_addr == addr);
    assign bus.rd_data[gi*DATA_W +: DATA_W] = hit ? bus.wr_data : stored;
    assign bus.rd_busy[gi] = nonzero && pending_vec[addr] && !hit;
`else
    assign bus.rd_data[gi*DATA_W +: DATA_W] = stored;
    assign bus.rd_busy[gi] = nonzero && pending_vec[addr];
`endif
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed test-plan steps followed by random
// traffic, all checked against an array-based model of the register file and scoreboard.
module tb_register_file_sb;
  import regfile_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] ref_mem  [DEPTH];
  bit          ref_pend [DEPTH];
  bit          in_reset;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (in_reset || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
    return ref_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (in_reset || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) return 1'b0;
`endif
    return ref_pend[a];
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] v;
    v = '0;
    if (!in_reset) for (int r = 0; r < DEPTH; r++) v[r] = ref_pend[r];
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [4:0] a;
    for (int p = 0; p < NUM_RD; p++) begin
      a = bus.rd_addr[p*ADDR_W +: ADDR_W];
      check_val($sformatf("%s data%0d r%0d", tag, p, a), bus.rd_data[p*DATA_W +: DATA_W], exp_data(a));
      check_val($sformatf("%s busy%0d r%0d", tag, p, a), {31'h0, bus.rd_busy[p]}, {31'h0, exp_busy(a)});
    end
    check_val({tag, " pending"}, bus.pending, exp_pending());
  endtask

  task automatic model_edge();
    if (bus.flush) begin
      for (int r = 0; r < DEPTH; r++) ref_pend[r] = 1'b0;
    end else begin
      if (bus.wr_en) ref_pend[bus.wr_addr] = 1'b0;
      if (bus.issue_en && bus.issue_addr != 5'd0) ref_pend[bus.issue_addr] = 1'b1;
    end
    if (bus.wr_en && bus.wr_addr != 5'd0) ref_mem[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic apply_stimulus(input string tag,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia, input logic fl,
                                input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    bus.flush      = fl;
    bus.rd_addr    = {r1, r0};
    #1;
    check_output(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle(input logic [4:0] r0, input logic [4:0] r1);
    bus.wr_en    = 1'b0;
    bus.issue_en = 1'b0;
    bus.flush    = 1'b0;
    bus.rd_addr  = {r1, r0};
    #1;
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      ref_mem[r]  = '0;
      ref_pend[r] = 1'b0;
    end
    in_reset       = 1'b1;
    rst_n          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.flush      = 1'b0;
    bus.rd_addr    = '0;

    #12;
    check_output("in_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;

    for (int r = 0; r < DEPTH; r += 2)
      apply_stimulus("after_reset", 0, 0, 0, 0, 0, 0, 5'(r), 5'(r + 1));

    apply_stimulus("wr_r5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    apply_stimulus("wr_r0", 1, 0, 32'h1, 0, 0, 0, 5, 0);
    set_idle(5, 0);
    check_val("r5_direct", bus.rd_data[31:0], 32'hDEADBEEF);
    check_val("r0_direct", bus.rd_data[63:32], 32'h0);

    apply_stimulus("issue_r7", 0, 0, 0, 1, 7, 0, 7, 7);
    apply_stimulus("idle1_r7", 0, 0, 0, 0, 0, 0, 7, 7);
    apply_stimulus("idle2_r7", 0, 0, 0, 0, 0, 0, 7, 7);
    apply_stimulus("wr_r7", 1, 7, 32'h55, 0, 0, 0, 7, 7);
    set_idle(7, 7);
    check_val("r7_busy_after", {31'h0, bus.rd_busy[0]}, 32'h0);
    check_val("r7_data_after", bus.rd_data[31:0], 32'h55);

    apply_stimulus("issue_wr_r9", 1, 9, 32'h10, 1, 9, 0, 9, 1);
    set_idle(9, 9);
    check_val("r9_data", bus.rd_data[31:0], 32'h10);
    check_val("r9_pending", {31'h0, bus.pending[9]}, 32'h1);

    apply_stimulus("issue_r3", 0, 0, 0, 1, 3, 0, 3, 4);
    apply_stimulus("issue_r4", 0, 0, 0, 1, 4, 0, 3, 4);
    apply_stimulus("issue_r8", 0, 0, 0, 1, 8, 0, 8, 3);
    apply_stimulus("flush_wr_r3", 1, 3, 32'h77, 0, 0, 1, 3, 8);
    set_idle(3, 8);
    check_val("flush_pending", bus.pending, 32'h0);
    check_val("flush_r3", bus.rd_data[31:0], 32'h77);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, ia, r0, r1;
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 7));
      apply_stimulus("random", 1'($urandom_range(0, 1)), wa, $urandom,
                     1'($urandom_range(0, 2) == 0), ia, 1'($urandom_range(0, 15) == 0), r0, r1);
    end

    apply_stimulus("pre_rst_issue", 0, 0, 0, 1, 2, 0, 2, 6);
    apply_stimulus("pre_rst_issue6", 0, 0, 0, 1, 6, 0, 2, 6);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd2;
    bus.wr_data  = 32'hAA;
    bus.issue_en = 1'b0;
    bus.flush    = 1'b0;
    bus.rd_addr  = {5'd6, 5'd2};
    #1;
    check_output("pre_rst");
    #1;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      ref_mem[r]  = '0;
      ref_pend[r] = 1'b0;
    end
    #1;
    check_output("mid_rst");
    check_val("mid_rst_r2", bus.rd_data[31:0], 32'h0);
    @(posedge clk);
    #1;
    check_output("rst_edge");
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    set_idle(2, 6);
    check_output("post_rst");
    check_val("post_rst_r2", bus.rd_data[31:0], 32'h0);
    apply_stimulus("post_rst_wr", 1, 2, 32'h1234, 0, 0, 0, 2, 6);
    apply_stimulus("post_rst_rd", 0, 0, 0, 0, 0, 0, 2, 2);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
